wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback pipeline stage directly upstream of the 32x64 register file.
- Latches the instruction leaving the memory stage and aligns and sign-/zero-extends load data.
- Drives the regfile write port (waddr/wdata/wen) and publishes one commit record per retired instruction for difftest.
- Maintains a retired-instruction counter and a sticky halt on EBREAK.

Parameters:
- XLEN, 64, datapath and register width
- RA_W, 5, register address width
- EBREAK_INST, 32'h00100073, encoding that raises halt

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept; = ~halt & ~stall
- stall  in  1  external hold; blocks acceptance only
- in_pc  in  XLEN  instruction PC
- in_inst  in  32  instruction word
- in_rd  in  RA_W  destination register
- in_rd_wen  in  1  instruction writes rd
- in_is_load  in  1  result comes from memory
- in_ld_funct3  in  3  load type (LB=000 LH=001 LW=010 LD=011 LBU=100 LHU=101 LWU=110)
- in_addr_low  in  3  load address bits [2:0]
- in_mem_rdata  in  XLEN  raw 8-byte-aligned doubleword from memory
- in_alu_res  in  XLEN  non-load result
- rf_waddr  out  RA_W  regfile write address
- rf_wdata  out  XLEN  regfile write data
- rf_wen  out  1  regfile write enable
- commit_valid  out  1  one-cycle pulse per retired instruction
- commit_pc  out  XLEN  PC of the committed instruction
- commit_inst  out  32  word of the committed instruction
- instret  out  64  count of retired instructions
- halt  out  1  sticky; set by a committed EBREAK
- ld_err  out  1  sticky; misaligned load or illegal load funct3

Behaviour:
- Single clock domain. All state resets synchronously while rst=1. rst has priority over every other event, including a simultaneous EBREAK commit.
- Reset values: commit_valid=0, rf_wen=0, rf_waddr=0, rf_wdata=0, commit_pc=0, commit_inst=0, instret=0, halt=0, ld_err=0.
- Accept: on a clock edge with in_valid & in_ready, the stage registers the input fields plus the already-computed writeback data. Latency is exactly 1 cycle from accept to commit_valid and rf_wen.
- No accept (in_valid=0, stall=1, or halt=1): the valid bit clears. The stage presents a bubble; it never re-presents an old instruction.
- Each accepted instruction is therefore visible for exactly one cycle. The regfile write is never duplicated.
- rf_wen = valid & rd_wen & (rd != 0) & ~misalign. A commit with rd=0 still pulses commit_valid.
- Load extraction is combinational before the register. Byte offset = in_addr_low.
  - LB/LBU: byte at offset*8, sign-/zero-extended.
  - LH/LHU: halfword; requires addr_low[0]=0.
  - LW/LWU: word; requires addr_low[1:0]=0.
  - LD: requires addr_low=0.
- Misaligned load: commit still pulses, rf_wen is forced to 0, and ld_err is set.
- funct3=111: wdata=0, rf_wen=0, ld_err is set.
- Non-load: wdata = in_alu_res.
- instret increments by 1 on each commit_valid and wraps from 2^64-1 to 0.
- Halt: when the committed inst equals EBREAK_INST, halt becomes 1 on the next edge and stays 1 until rst. in_ready then stays 0. The EBREAK itself commits normally and is counted in instret.
- halt and ld_err are sticky until rst.

Decomposition:
- Shared package holds: XLEN, RA_W, load funct3 constants, EBREAK_INST, and the writeback payload struct (pc, inst, rd, rd_wen, data).
- One combinational sub-module: wb_load_align. Inputs are funct3, addr_low and rdata. Outputs are the extended data, a misalign flag and an illegal flag.
- The sequential register, counter and flags stay in wb_stage.

Test Plan:
- Reset then non-load: rd=5, alu_res=0x1234, accepted at cycle N -> rf_wen=1, waddr=5, wdata=0x1234 at N+1 only; instret=1.
- LB, addr_low=3, rdata=0x00000000_80000000 -> wdata=0xFFFFFFFF_FFFFFF80. Same input with LBU -> wdata=0x80.
- LW, addr_low=2 -> commit_valid=1, rf_wen=0, ld_err=1 and stays 1. Subsequent aligned LD at addr_low=0, rdata=0xDEADBEEF_CAFEF00D -> full value written.
- stall=1 for 3 cycles with in_valid=1 -> in_ready=0, no commit_valid and no rf_wen during stall. On release, exactly one commit per accepted instruction.
- Write to rd=0, alu_res=0xFF -> commit_valid=1, rf_wen=0, instret increments.
- EBREAK committed -> halt=1 the next cycle, in_ready=0, further in_valid ignored, instret includes the EBREAK. rst=1 -> all outputs return to 0 the next edge.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// ----------------------------------------------------------------------------
// wb_stage_pkg
// Shared definitions for the writeback stage: datapath widths, load funct3
// encodings, the EBREAK encoding that halts the core, and the payload struct
// carried from the accept edge to the commit cycle.
// ----------------------------------------------------------------------------
package wb_stage_pkg;

    localparam int XLEN = 64;
    localparam int RA_W = 5;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [RA_W-1:0] rd;
        logic            rd_wen;
        logic [XLEN-1:0] data;
    } wb_payload_t;

endpackage

// File: rtl/wb_load_align.sv
// ----------------------------------------------------------------------------
// wb_load_align
// Purely combinational load extraction: selects the byte/half/word/double
// addressed by i_addr_low out of an 8-byte-aligned doubleword and sign- or
// zero-extends it to XLEN.
// Ports:
//   i_funct3   load type
//   i_addr_low load address bits [2:0] (byte offset in the doubleword)
//   i_rdata    raw doubleword from memory
//   o_data     extended load result (0 for an illegal funct3)
//   o_misalign access not naturally aligned for its size
//   o_illegal  funct3 does not encode a load
// ----------------------------------------------------------------------------
module wb_load_align
    import wb_stage_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [2:0]      i_addr_low,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_data,
    output logic            o_misalign,
    output logic            o_illegal
);

    logic [XLEN-1:0] w_shift;

    always_comb begin
        // Bring the addressed byte down to bit 0; each case then only looks
        // at the low bits it needs.
        w_shift    = i_rdata >> {i_addr_low, 3'b000};
        o_data     = '0;
        o_misalign = 1'b0;
        o_illegal  = 1'b0;
        case (i_funct3)
            F3_LB:  o_data = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
            F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_shift[7:0]};
            F3_LH: begin
                o_data     = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
                o_misalign = i_addr_low[0];
            end
            F3_LHU: begin
                o_data     = {{(XLEN-16){1'b0}}, w_shift[15:0]};
                o_misalign = i_addr_low[0];
            end
            F3_LW: begin
                o_data     = {{(XLEN-32){w_shift[31]}}, w_shift[31:0]};
                o_misalign = |i_addr_low[1:0];
            end
            F3_LWU: begin
                o_data     = {{(XLEN-32){1'b0}}, w_shift[31:0]};
                o_misalign = |i_addr_low[1:0];
            end
            F3_LD: begin
                o_data     = i_rdata;
                o_misalign = |i_addr_low;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage
// Writeback stage in front of the 32x64 register file. Registers the
// instruction leaving the memory stage together with its final writeback
// data, drives the regfile write port for exactly one cycle, publishes a
// commit record, counts retired instructions and halts on EBREAK.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; stall only blocks acceptance
//   in_pc/in_inst       instruction identity for the commit record
//   in_rd/in_rd_wen     destination register and its write request
//   in_is_load ...      load type, byte offset and raw memory doubleword
//   in_alu_res          result for non-load instructions
//   rf_waddr/wdata/wen  regfile write port
//   commit_*            one-cycle commit record per retired instruction
//   instret             retired-instruction counter (wraps)
//   halt, ld_err        sticky status flags, cleared only by rst
// ----------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] P_EBREAK_INST = EBREAK_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            stall,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    input  logic [RA_W-1:0] in_rd,
    input  logic            in_rd_wen,
    input  logic            in_is_load,
    input  logic [2:0]      in_ld_funct3,
    input  logic [2:0]      in_addr_low,
    input  logic [XLEN-1:0] in_mem_rdata,
    input  logic [XLEN-1:0] in_alu_res,
    output logic [RA_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            rf_wen,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [31:0]     commit_inst,
    output logic [63:0]     instret,
    output logic            halt,
    output logic            ld_err
);

    logic [XLEN-1:0] w_ld_data;
    logic            w_misalign;
    logic            w_illegal;
    logic            w_ld_bad;
    logic            w_accept;
    logic [XLEN-1:0] w_wb_data;

    logic            r_valid;
    wb_payload_t     r_pl;
    logic            r_ld_bad;
    logic [63:0]     r_instret;
    logic            r_halt;
    logic            r_ld_err;

    wb_load_align u_load_align (
        .i_funct3   (in_ld_funct3),
        .i_addr_low (in_addr_low),
        .i_rdata    (in_mem_rdata),
        .o_data     (w_ld_data),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal)
    );

    assign in_ready  = ~r_halt & ~stall;
    assign w_accept  = in_valid & in_ready;
    assign w_ld_bad  = in_is_load & (w_misalign | w_illegal);
    assign w_wb_data = in_is_load ? w_ld_data : in_alu_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pl      <= '0;
            r_ld_bad  <= 1'b0;
            r_instret <= '0;
            r_halt    <= 1'b0;
            r_ld_err  <= 1'b0;
        end else begin
            // Valid is rebuilt every edge, so an instruction is shown once
            // and a non-accepting edge always leaves a bubble.
            r_valid <= w_accept;
            if (w_accept) begin
                r_pl.pc     <= in_pc;
                r_pl.inst   <= in_inst;
                r_pl.rd     <= in_rd;
                r_pl.rd_wen <= in_rd_wen;
                r_pl.data   <= w_wb_data;
                r_ld_bad    <= w_ld_bad;
            end
            if (r_valid) begin
                r_instret <= r_instret + 64'd1;
            end
            if (r_valid && (r_pl.inst == P_EBREAK_INST)) begin
                r_halt <= 1'b1;
            end
            if (w_accept && w_ld_bad) begin
                r_ld_err <= 1'b1;
            end
        end
    end

    assign commit_valid = r_valid;
    assign commit_pc    = r_pl.pc;
    assign commit_inst  = r_pl.inst;
    assign rf_waddr     = r_pl.rd;
    assign rf_wdata     = r_pl.data;
    // A bad load still commits but must never reach the regfile.
    assign rf_wen       = r_valid & r_pl.rd_wen & (r_pl.rd != '0) & ~r_ld_bad;
    assign instret      = r_instret;
    assign halt         = r_halt;
    assign ld_err       = r_ld_err;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            stall;
    logic [63:0]     in_pc;
    logic [31:0]     in_inst;
    logic [4:0]      in_rd;
    logic            in_rd_wen;
    logic            in_is_load;
    logic [2:0]      in_ld_funct3;
    logic [2:0]      in_addr_low;
    logic [63:0]     in_mem_rdata;
    logic [63:0]     in_alu_res;
    logic [4:0]      rf_waddr;
    logic [63:0]     rf_wdata;
    logic            rf_wen;
    logic            commit_valid;
    logic [63:0]     commit_pc;
    logic [31:0]     commit_inst;
    logic [63:0]     instret;
    logic            halt;
    logic            ld_err;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .stall        (stall),
        .in_pc        (in_pc),
        .in_inst      (in_inst),
        .in_rd        (in_rd),
        .in_rd_wen    (in_rd_wen),
        .in_is_load   (in_is_load),
        .in_ld_funct3 (in_ld_funct3),
        .in_addr_low  (in_addr_low),
        .in_mem_rdata (in_mem_rdata),
        .in_alu_res   (in_alu_res),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_wen       (rf_wen),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .instret      (instret),
        .halt         (halt),
        .ld_err       (ld_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what the outputs must show after the last edge.
    logic [63:0] m_instret = '0;
    logic        m_halt    = 1'b0;
    logic        m_ld_err  = 1'b0;
    logic        m_cv      = 1'b0;
    logic        m_wen     = 1'b0;
    logic        m_wd_chk  = 1'b0;
    logic [4:0]  m_waddr   = '0;
    logic [63:0] m_wdata   = '0;
    logic [63:0] m_pc      = '0;
    logic [31:0] m_inst    = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Load semantics from access size and signedness, not from a case table.
    function automatic void ref_load(input logic [2:0] f3, input logic [2:0] off,
                                     input logic [63:0] rdata, output logic [63:0] data,
                                     output logic bad, output logic illegal);
        int          nbytes;
        logic [63:0] mask;
        logic [63:0] raw;
        illegal = (f3 == 3'd7);
        nbytes  = 1 << f3[1:0];
        bad     = illegal || ((int'(off) % nbytes) != 0);
        mask    = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nbytes * 8)) - 64'd1);
        raw     = (rdata >> (int'(off) * 8)) & mask;
        if (!f3[2] && nbytes < 8 && raw[nbytes*8-1]) raw = raw | ~mask;
        data = illegal ? 64'd0 : raw;
    endfunction

    task automatic set_in(input logic v, input logic st, input logic [63:0] pc,
                          input logic [31:0] inst, input logic [4:0] rd, input logic rdw,
                          input logic ld, input logic [2:0] f3, input logic [2:0] off,
                          input logic [63:0] rdata, input logic [63:0] alu);
        in_valid = v;      stall = st;       in_pc = pc;        in_inst = inst;
        in_rd = rd;        in_rd_wen = rdw;  in_is_load = ld;   in_ld_funct3 = f3;
        in_addr_low = off; in_mem_rdata = rdata; in_alu_res = alu;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 64'd0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0);
    endtask

    // One clock: check in_ready before the edge, advance the model, check after.
    task automatic step(input string tag);
        logic        acc, bad, ill;
        logic [63:0] d;
        #1;
        if (!rst) chk({tag, ":in_ready"}, 64'(in_ready), 64'(!m_halt && !stall));
        @(posedge clk);
        if (rst) begin
            m_instret = '0; m_halt = 1'b0; m_ld_err = 1'b0; m_cv = 1'b0; m_wen = 1'b0;
            m_wd_chk = 1'b1; m_waddr = '0; m_wdata = '0; m_pc = '0; m_inst = '0;
        end else begin
            acc = in_valid && !m_halt && !stall;
            if (m_cv) m_instret = m_instret + 64'd1;
            if (m_cv && m_inst == EBREAK_INST) m_halt = 1'b1;
            m_cv = acc;
            if (acc) begin
                m_pc = in_pc; m_inst = in_inst; m_waddr = in_rd;
                if (in_is_load) ref_load(in_ld_funct3, in_addr_low, in_mem_rdata, d, bad, ill);
                else begin d = in_alu_res; bad = 1'b0; ill = 1'b0; end
                m_wdata  = d;
                m_wen    = in_rd_wen && (in_rd != 5'd0) && !bad;
                m_wd_chk = !(bad && !ill);
                if (bad) m_ld_err = 1'b1;
            end
        end
        #1;
        chk({tag, ":commit_valid"}, 64'(commit_valid), 64'(m_cv));
        chk({tag, ":rf_wen"}, 64'(rf_wen), 64'(m_cv && m_wen));
        chk({tag, ":instret"}, instret, m_instret);
        chk({tag, ":halt"}, 64'(halt), 64'(m_halt));
        chk({tag, ":ld_err"}, 64'(ld_err), 64'(m_ld_err));
        chk({tag, ":rf_waddr"}, 64'(rf_waddr), 64'(m_waddr));
        chk({tag, ":commit_pc"}, commit_pc, m_pc);
        chk({tag, ":commit_inst"}, 64'(commit_inst), 64'(m_inst));
        if (m_wd_chk) chk({tag, ":rf_wdata"}, rf_wdata, m_wdata);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step("reset0");
        step("reset1");
        rst = 1'b0;

        // Non-load write, then a bubble: write must not repeat.
        set_in(1'b1, 1'b0, 64'h100, 32'h0000_0013, 5'd5, 1'b1, 1'b0, 3'd0, 3'd0, 64'd0, 64'h1234);
        step("alu_rd5");
        idle();
        step("alu_bubble");
        step("alu_instret");

        // LB / LBU at byte offset 3.
        set_in(1'b1, 1'b0, 64'h104, 32'h0031_8283, 5'd6, 1'b1, 1'b1, F3_LB, 3'd3, 64'h0000_0000_8000_0000, 64'd0);
        step("lb_off3");
        set_in(1'b1, 1'b0, 64'h108, 32'h0031_c283, 5'd7, 1'b1, 1'b1, F3_LBU, 3'd3, 64'h0000_0000_8000_0000, 64'd0);
        step("lbu_off3");

        // Misaligned LW, then aligned LD.
        set_in(1'b1, 1'b0, 64'h10C, 32'h0021_a283, 5'd8, 1'b1, 1'b1, F3_LW, 3'd2, 64'h1111_2222_3333_4444, 64'd0);
        step("lw_misalign");
        set_in(1'b1, 1'b0, 64'h110, 32'h0001_b283, 5'd9, 1'b1, 1'b1, F3_LD, 3'd0, 64'hDEAD_BEEF_CAFE_F00D, 64'd0);
        step("ld_aligned");
        set_in(1'b1, 1'b0, 64'h114, 32'h0001_f283, 5'd10, 1'b1, 1'b1, 3'd7, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        step("f3_illegal");

        // Stall with valid held for three cycles, then release.
        set_in(1'b1, 1'b1, 64'h118, 32'h0000_0093, 5'd11, 1'b1, 1'b0, 3'd0, 3'd0, 64'd0, 64'h55AA);
        for (int i = 0; i < 3; i++) step("stall");
        stall = 1'b0;
        step("stall_release");
        idle();
        step("stall_after");

        // rd=0 commits but never writes.
        set_in(1'b1, 1'b0, 64'h11C, 32'h0ff0_0013, 5'd0, 1'b1, 1'b0, 3'd0, 3'd0, 64'd0, 64'hFF);
        step("rd0");
        idle();
        step("rd0_after");

        // Randomized traffic, EBREAK excluded so the stage keeps running.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] inst;
            inst = $urandom;
            if (inst == EBREAK_INST) inst = 32'h0000_0013;
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                   {$urandom, $urandom}, inst, 5'($urandom_range(0, 31)), 1'($urandom),
                   1'($urandom), 3'($urandom), 3'($urandom), {$urandom, $urandom},
                   {$urandom, $urandom});
            step("random");
        end

        // rst wins over an EBREAK committing in the same cycle.
        set_in(1'b1, 1'b0, 64'h200, EBREAK_INST, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0);
        step("ebrk_a_accept");
        idle();
        rst = 1'b1;
        step("ebrk_a_rst");
        rst = 1'b0;
        step("ebrk_a_after");

        // EBREAK halts the stage; later traffic is ignored.
        set_in(1'b1, 1'b0, 64'h300, 32'h0000_0013, 5'd3, 1'b1, 1'b0, 3'd0, 3'd0, 64'd0, 64'h77);
        step("pre_ebrk");
        set_in(1'b1, 1'b0, 64'h304, EBREAK_INST, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0);
        step("ebrk_accept");
        set_in(1'b1, 1'b0, 64'h308, 32'h0000_0013, 5'd4, 1'b1, 1'b0, 3'd0, 3'd0, 64'd0, 64'h99);
        step("ebrk_commit");
        for (int i = 0; i < 4; i++) step("halted");

        rst = 1'b1;
        idle();
        step("final_rst");
        rst = 1'b0;
        step("final_after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
